// File: rtl/nand_apb_host_if_if.sv
// Bus bundle for nand_apb_host_if: APB slave port plus the beat stream to the NAND fsm.
// slave = the host block; master = APB master and NAND fsm side.
interface nand_apb_host_if_if;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [5:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;
    logic [7:0] C_Cmd;
    logic [7:0] C_Addr;
    logic [7:0] C_WrData;
    logic [7:0] C_Length;
    logic [7:0] C_Status;
    logic [1:0] C_Phase;
    logic       C_Valid;
    logic       C_Ready;
    logic [7:0] C_RdData;

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR,
        output C_Cmd, C_Addr, C_WrData, C_Length,
        output C_Status, C_Phase, C_Valid,
        input  C_Ready, C_RdData
    );

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR,
        input  C_Cmd, C_Addr, C_WrData, C_Length,
        input  C_Status, C_Phase, C_Valid,
        output C_Ready, C_RdData
    );
endinterface

// File: rtl/nand_apb_host_if.sv
// APB register slave and beat sequencer feeding the NAND fsm (CMD1, ADDR, DATA, CMD2).
// Define NAND_HOST_IRQ_EN to add the IRQEN register (offset 30) and a live IRQ.
module nand_apb_host_if #(
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_ADDR   = 5
) (
    input  logic              P_clk,
    input  logic              P_nrst,
    nand_apb_host_if_if.slave bus,
    output logic              IRQ
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [2:0] NMAX = 3'(MAX_ADDR);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD1, S_ADDR, S_DATA, S_CMD2, S_DONE
    } state_t;

    state_t state, state_d;
    state_t after_cmd1, after_addr, after_data;

    logic [7:0] cmd1, cmd2, length, cnt, cnt_d;
    logic [7:0] addr_r [8];
    logic       wr_en, rd_en, cmd2_en;
    logic [2:0] naddr, naddr_w;
    logic       done_f, done_d, abort_f, abort_d;
    logic       valid_r, valid_d;

    logic [7:0]    wf_mem [FIFO_DEPTH];
    logic [7:0]    rf_mem [FIFO_DEPTH];
    logic [AW-1:0] wf_rp, wf_wp, rf_rp, rf_wp;
    logic [CW-1:0] wf_cnt, rf_cnt, wf_cnt_nx, rf_cnt_nx;
    logic          wf_full, wf_empty, rf_full, rf_empty;

    logic       acc, busy, err_c, we, re;
    logic       hit_ctrl, hit_cmd1, hit_cmd2, hit_addr, hit_len;
    logic       hit_wd, hit_rd, hit_stat, hit_irqen, mapped;
    logic [5:0] aoff;
    logic [2:0] addr_idx;
    logic [7:0] rd_c, stat;
    logic       w_ctrl, start, abort, stat_w1c;
    logic       wf_push, wf_pop, rf_push, rf_pop;
    logic       fire, data_en, data_ok;
    logic [1:0] phase_c;

    assign acc      = bus.PSEL & bus.PENABLE;
    assign busy     = (state != S_IDLE);
    assign wf_full  = (wf_cnt == FULL);
    assign wf_empty = (wf_cnt == '0);
    assign rf_full  = (rf_cnt == FULL);
    assign rf_empty = (rf_cnt == '0);
    assign aoff     = bus.PADDR - 6'h0C;
    assign addr_idx = aoff[4:2];
    assign naddr_w  = (bus.PWDATA[7:5] > NMAX) ? NMAX : bus.PWDATA[7:5];

    assign hit_ctrl = (bus.PADDR == 6'h00);
    assign hit_cmd1 = (bus.PADDR == 6'h04);
    assign hit_cmd2 = (bus.PADDR == 6'h08);
    assign hit_len  = (bus.PADDR == 6'h20);
    assign hit_wd   = (bus.PADDR == 6'h24);
    assign hit_rd   = (bus.PADDR == 6'h28);
    assign hit_stat = (bus.PADDR == 6'h2C);
    assign hit_addr = (bus.PADDR >= 6'h0C) && (aoff[1:0] == 2'b00)
                   && (int'(aoff[5:2]) < MAX_ADDR);
`ifdef NAND_HOST_IRQ_EN
    assign hit_irqen = (bus.PADDR == 6'h30);
`else
    assign hit_irqen = 1'b0;
`endif
    assign mapped = hit_ctrl | hit_cmd1 | hit_cmd2 | hit_addr | hit_len
                  | hit_wd | hit_rd | hit_stat | hit_irqen;

    // An error access must leave every register and FIFO untouched.
    always_comb begin
        err_c = 1'b0;
        if (!mapped) begin
            err_c = 1'b1;
        end else if (bus.PWRITE) begin
            if (hit_wd && wf_full)
                err_c = 1'b1;
            if (busy && (hit_cmd1 | hit_cmd2 | hit_addr | hit_len))
                err_c = 1'b1;
            if (hit_ctrl && busy &&
                (bus.PWDATA[0] || bus.PWDATA[2] != wr_en ||
                 bus.PWDATA[3] != rd_en || naddr_w != naddr))
                err_c = 1'b1;
            if (hit_ctrl && !busy && bus.PWDATA[0] &&
                bus.PWDATA[3:2] == 2'b11)
                err_c = 1'b1;
        end else if (hit_rd && rf_empty) begin
            err_c = 1'b1;
        end
    end

    assign we       = acc & bus.PWRITE & ~err_c;
    assign re       = acc & ~bus.PWRITE & ~err_c;
    assign w_ctrl   = we & hit_ctrl;
    assign start    = w_ctrl & bus.PWDATA[0];
    assign abort    = w_ctrl & bus.PWDATA[1];
    assign stat_w1c = we & hit_stat;
    assign wf_push  = we & hit_wd;
    assign rf_pop   = re & hit_rd;

    assign stat = {1'b0, rf_empty, rf_full, wf_empty, wf_full,
                   abort_f, done_f, busy};

`ifdef NAND_HOST_IRQ_EN
    logic [1:0] irqen, irqen_d;
    logic       irq_r;
    assign irqen_d = (we && hit_irqen) ? bus.PWDATA[1:0] : irqen;
    assign IRQ     = irq_r;
`else
    assign IRQ = 1'b0;
`endif

    always_comb begin
        rd_c = 8'h00;
        unique case (1'b1)
            hit_ctrl:  rd_c = {naddr, cmd2_en, rd_en, wr_en, 2'b00};
            hit_cmd1:  rd_c = cmd1;
            hit_cmd2:  rd_c = cmd2;
            hit_addr:  rd_c = addr_r[addr_idx];
            hit_len:   rd_c = length;
            hit_wd:    rd_c = 8'h00;
            hit_rd:    rd_c = rf_mem[rf_rp];
            hit_stat:  rd_c = stat;
`ifdef NAND_HOST_IRQ_EN
            hit_irqen: rd_c = {6'b0, irqen};
`endif
            default:   rd_c = 8'h00;
        endcase
    end

    assign bus.PRDATA  = re ? rd_c : 8'h00;
    assign bus.PREADY  = 1'b1;
    assign bus.PSLVERR = acc & err_c;

    assign fire      = valid_r & bus.C_Ready;
    assign data_en   = (length != 8'd0) && (wr_en | rd_en);
    assign wf_pop    = fire && (state == S_DATA) && wr_en;
    assign rf_push   = fire && (state == S_DATA) && rd_en;
    assign wf_cnt_nx = wf_cnt + CW'(wf_push) - CW'(wf_pop);
    assign rf_cnt_nx = rf_cnt + CW'(rf_push) - CW'(rf_pop);
    // Look at next-cycle occupancy so an offered beat never outruns the FIFO.
    assign data_ok   = wr_en ? (wf_cnt_nx != '0) : (rf_cnt_nx != FULL);

    assign after_data = cmd2_en ? S_CMD2 : S_DONE;
    assign after_addr = data_en ? S_DATA : after_data;
    assign after_cmd1 = (naddr != 3'd0) ? S_ADDR : after_addr;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        done_d  = done_f;
        abort_d = abort_f;
        valid_d = 1'b0;
        if (stat_w1c && bus.PWDATA[1])
            done_d = 1'b0;
        if (stat_w1c && bus.PWDATA[2])
            abort_d = 1'b0;
        unique case (state)
            S_IDLE: if (start) state_d = S_CMD1;
            S_CMD1: if (fire) state_d = after_cmd1;
            S_ADDR: if (fire) begin
                if (cnt == {5'b0, naddr} - 8'd1) begin
                    state_d = after_addr;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            S_DATA: if (fire) begin
                if (cnt == length - 8'd1) begin
                    state_d = after_data;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            S_CMD2: if (fire) state_d = S_DONE;
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        unique case (state_d)
            S_CMD1, S_ADDR, S_CMD2: valid_d = 1'b1;
            S_DATA:                 valid_d = data_ok;
            default:                valid_d = 1'b0;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            cnt_d   = 8'd0;
            done_d  = done_f;
            if (busy)
                abort_d = 1'b1;
        end
    end

    always_comb begin
        phase_c = 2'd0;
        unique case (state)
            S_ADDR:  phase_c = 2'd1;
            S_DATA:  phase_c = 2'd2;
            S_CMD2:  phase_c = 2'd3;
            default: phase_c = 2'd0;
        endcase
    end

    assign bus.C_Cmd    = (state == S_CMD2) ? cmd2 : cmd1;
    assign bus.C_Addr   = addr_r[cnt[2:0]];
    assign bus.C_WrData = wf_mem[wf_rp];
    assign bus.C_Length = length;
    assign bus.C_Status = {5'b0, cmd2_en, rd_en, wr_en};
    assign bus.C_Phase  = phase_c;
    assign bus.C_Valid  = valid_r;

    always_ff @(posedge P_clk or negedge P_nrst) begin
        if (!P_nrst) begin
            state   <= S_IDLE;
            cnt     <= 8'd0;
            valid_r <= 1'b0;
            done_f  <= 1'b0;
            abort_f <= 1'b0;
            cmd1    <= 8'd0;
            cmd2    <= 8'd0;
            length  <= 8'd0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            cmd2_en <= 1'b0;
            naddr   <= 3'd0;
            wf_rp   <= '0;
            wf_wp   <= '0;
            wf_cnt  <= '0;
            rf_rp   <= '0;
            rf_wp   <= '0;
            rf_cnt  <= '0;
            for (int i = 0; i < 8; i++)
                addr_r[i] <= 8'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                wf_mem[i] <= 8'd0;
                rf_mem[i] <= 8'd0;
            end
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            valid_r <= valid_d;
            done_f  <= done_d;
            abort_f <= abort_d;
            if (w_ctrl) begin
                wr_en   <= bus.PWDATA[2];
                rd_en   <= bus.PWDATA[3];
                cmd2_en <= bus.PWDATA[4];
                naddr   <= naddr_w;
            end
            if (we && hit_cmd1) cmd1 <= bus.PWDATA;
            if (we && hit_cmd2) cmd2 <= bus.PWDATA;
            if (we && hit_len)  length <= bus.PWDATA;
            if (we && hit_addr) addr_r[addr_idx] <= bus.PWDATA;
            if (abort) begin
                wf_rp  <= '0;
                wf_wp  <= '0;
                wf_cnt <= '0;
                rf_rp  <= '0;
                rf_wp  <= '0;
                rf_cnt <= '0;
            end else begin
                if (wf_push) begin
                    wf_mem[wf_wp] <= bus.PWDATA;
                    wf_wp <= wf_wp + AW'(1);
                end
                if (wf_pop)
                    wf_rp <= wf_rp + AW'(1);
                if (rf_push) begin
                    rf_mem[rf_wp] <= bus.C_RdData;
                    rf_wp <= rf_wp + AW'(1);
                end
                if (rf_pop)
                    rf_rp <= rf_rp + AW'(1);
                wf_cnt <= wf_cnt_nx;
                rf_cnt <= rf_cnt_nx;
            end
        end
    end

`ifdef NAND_HOST_IRQ_EN
    always_ff @(posedge P_clk or negedge P_nrst) begin
        if (!P_nrst) begin
            irqen <= 2'b00;
            irq_r <= 1'b0;
        end else begin
            irqen <= irqen_d;
            irq_r <= (done_d & irqen_d[0]) | (abort_d & irqen_d[1]);
        end
    end
`endif

endmodule

// File: tb/tb_nand_apb_host_if.sv
// Directed bench for nand_apb_host_if: erase, program, read stall,
// error responses, abort and mid-run reset.
module tb_nand_apb_host_if;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic irq;
    int   total = 0;
    int   bad = 0;
    int   rd_cnt = 0;
    int   cyc;
    logic [7:0] r;
    logic       e;
    logic [9:0] got_q [$];
    logic [9:0] exp_q [$];

    always #5 clk = ~clk;

    nand_apb_host_if_if bus();

    nand_apb_host_if #(.FIFO_DEPTH(8), .MAX_ADDR(5)) dut (
        .P_clk (clk),
        .P_nrst(rst_n),
        .bus   (bus),
        .IRQ   (irq)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic apb(input logic wr, input logic [5:0] a,
                       input logic [7:0] d, output logic [7:0] rd,
                       output logic err);
        @(posedge clk); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
        bus.PWRITE = wr; bus.PADDR = a; bus.PWDATA = d;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        @(negedge clk);
        rd = bus.PRDATA;
        err = bus.PSLVERR;
        @(posedge clk); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    task automatic wreg(input logic [5:0] a, input logic [7:0] d);
        logic [7:0] x;
        logic       er;
        apb(1'b1, a, d, x, er);
        check($sformatf("werr_%02h", a), er, 0);
    endtask

    task automatic rchk(input string tag, input logic [5:0] a,
                        input logic [7:0] exp, input logic exp_err);
        logic [7:0] x;
        logic       er;
        apb(1'b0, a, 8'h00, x, er);
        check(tag, x, exp);
        check({tag, "_err"}, er, exp_err);
    endtask

    function automatic logic [7:0] pick();
        unique case (bus.C_Phase)
            2'd1:    return bus.C_Addr;
            2'd2:    return bus.C_Status[1] ? bus.C_RdData : bus.C_WrData;
            default: return bus.C_Cmd;
        endcase
    endfunction

    task automatic run_beats(input int n, input bit toggle, output int c);
        got_q.delete();
        c = 0;
        while (got_q.size() < n && c < 300) begin
            @(negedge clk);
            c++;
            if (toggle) bus.C_Ready = ~bus.C_Ready;
            bus.C_RdData = 8'hC0 + 8'(rd_cnt);
            #1;
            if (bus.C_Valid && bus.C_Ready) begin
                got_q.push_back({bus.C_Phase, pick()});
                if (bus.C_Phase == 2'd2 && bus.C_Status[1]) rd_cnt++;
            end
        end
        check("beat_count", got_q.size(), n);
        @(posedge clk); #1;
    endtask

    task automatic cmp_beats(input string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size())
                check($sformatf("%s_%0d", tag, i), got_q[i], exp_q[i]);
        end
    endtask

    task automatic pulse();
        @(negedge clk); bus.C_Ready = 1'b1;
        @(negedge clk); bus.C_Ready = 1'b0;
    endtask

    function automatic logic [63:0] outs();
        return {bus.C_Cmd, bus.C_Addr, bus.C_WrData, bus.C_Length,
                bus.C_Status, bus.C_Phase, bus.C_Valid,
                bus.PRDATA, bus.PSLVERR, irq};
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0;
        bus.PADDR = 0; bus.PWDATA = 0;
        bus.C_Ready = 0; bus.C_RdData = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_outs", outs(), 0);
        check("rst_pready", bus.PREADY, 1);
        rchk("rst_stat", 6'h2C, 8'h50, 0);

        // NADDR clamps to MAX_ADDR, START/ABORT read back as 0
        wreg(6'h00, 8'hE0);
        rchk("naddr_clamp", 6'h00, 8'hA0, 0);
        wreg(6'h00, 8'h00);

        // erase: consecutive beats
        wreg(6'h04, 8'h60); wreg(6'h08, 8'hD0);
        wreg(6'h0C, 8'hA0); wreg(6'h10, 8'hA1); wreg(6'h14, 8'hA2);
        bus.C_Ready = 1'b1;
        wreg(6'h00, 8'h71);
        run_beats(5, 0, cyc);
        check("erase_cycles", cyc, 5);
        exp_q = '{{2'd0, 8'h60}, {2'd1, 8'hA0}, {2'd1, 8'hA1},
                  {2'd1, 8'hA2}, {2'd3, 8'hD0}};
        cmp_beats("erase");
        bus.C_Ready = 1'b0;
        rchk("erase_stat", 6'h2C, 8'h52, 0);
        check("erase_idle", {bus.C_Valid, bus.C_Phase}, 0);

        // program with toggling ready
        wreg(6'h2C, 8'h02);
        wreg(6'h24, 8'h94); wreg(6'h24, 8'h87); wreg(6'h24, 8'h94);
        wreg(6'h24, 8'h78); wreg(6'h24, 8'hAA); wreg(6'h24, 8'hAB);
        wreg(6'h24, 8'hAC); wreg(6'h24, 8'hAD);
        rchk("wf_full_stat", 6'h2C, 8'h48, 0);
        wreg(6'h20, 8'h08); wreg(6'h04, 8'h80); wreg(6'h08, 8'h10);
        wreg(6'h0C, 8'h11); wreg(6'h10, 8'h22);
        wreg(6'h00, 8'h55);
        run_beats(12, 1, cyc);
        exp_q = '{{2'd0, 8'h80}, {2'd1, 8'h11}, {2'd1, 8'h22},
                  {2'd2, 8'h94}, {2'd2, 8'h87}, {2'd2, 8'h94},
                  {2'd2, 8'h78}, {2'd2, 8'hAA}, {2'd2, 8'hAB},
                  {2'd2, 8'hAC}, {2'd2, 8'hAD}, {2'd3, 8'h10}};
        cmp_beats("prog");
        bus.C_Ready = 1'b0;
        check("prog_status", bus.C_Status, 8'h05);
        check("prog_length", bus.C_Length, 8'h08);
        rchk("prog_stat", 6'h2C, 8'h52, 0);

        // read of 10 bytes stalls on a full read FIFO
        wreg(6'h2C, 8'h02);
        wreg(6'h20, 8'h0A); wreg(6'h04, 8'h00); wreg(6'h08, 8'h30);
        wreg(6'h0C, 8'h5A);
        rd_cnt = 0;
        bus.C_Ready = 1'b1;
        wreg(6'h00, 8'h39);
        run_beats(10, 0, cyc);
        exp_q = '{{2'd0, 8'h00}, {2'd1, 8'h5A}, {2'd2, 8'hC0},
                  {2'd2, 8'hC1}, {2'd2, 8'hC2}, {2'd2, 8'hC3},
                  {2'd2, 8'hC4}, {2'd2, 8'hC5}, {2'd2, 8'hC6},
                  {2'd2, 8'hC7}};
        cmp_beats("rd_a");
        repeat (3) @(negedge clk);
        check("rd_stall", {bus.C_Valid, bus.C_Phase}, {1'b0, 2'd2});
        bus.C_Ready = 1'b0;
        rchk("rd_full_stat", 6'h2C, 8'h31, 0);
        rchk("rd_pop0", 6'h28, 8'hC0, 0);
        rchk("rd_pop1", 6'h28, 8'hC1, 0);
        bus.C_Ready = 1'b1;
        run_beats(3, 0, cyc);
        exp_q = '{{2'd2, 8'hC8}, {2'd2, 8'hC9}, {2'd3, 8'h30}};
        cmp_beats("rd_b");
        bus.C_Ready = 1'b0;
        for (int i = 2; i < 10; i++)
            rchk($sformatf("rd_pop%0d", i), 6'h28, 8'hC0 + 8'(i), 0);
        rchk("rd_stat", 6'h2C, 8'h52, 0);

        // error responses
        wreg(6'h2C, 8'h02);
        for (int i = 0; i < 8; i++) wreg(6'h24, 8'h40 + 8'(i));
        apb(1'b1, 6'h24, 8'h99, r, e);
        check("push9_err", e, 1);
        rchk("push9_stat", 6'h2C, 8'h48, 0);
        wreg(6'h04, 8'h85); wreg(6'h0C, 8'h01);
        wreg(6'h10, 8'h02); wreg(6'h14, 8'h03);
        wreg(6'h20, 8'h08);
        wreg(6'h00, 8'h65);
        check("busy_cmd1", {bus.C_Valid, bus.C_Phase, bus.C_Cmd},
              {1'b1, 2'd0, 8'h85});
        apb(1'b1, 6'h00, 8'h65, r, e);
        check("start_busy_err", e, 1);
        apb(1'b1, 6'h04, 8'h77, r, e);
        check("cmd_busy_err", e, 1);
        rchk("cmd_kept", 6'h04, 8'h85, 0);
        rchk("pop_empty", 6'h28, 8'h00, 1);
        rchk("unmapped", 6'h34, 8'h00, 1);
        apb(1'b1, 6'h02, 8'h11, r, e);
        check("misaligned_err", e, 1);

        // abort during the second address beat
        pulse();
        check("abort_a0", {bus.C_Phase, bus.C_Addr}, {2'd1, 8'h01});
        pulse();
        check("abort_a1", {bus.C_Phase, bus.C_Addr}, {2'd1, 8'h02});
`ifdef NAND_HOST_IRQ_EN
        wreg(6'h30, 8'h02);
        check("irq_pre", irq, 0);
`endif
        wreg(6'h00, 8'h66);
        check("abort_idle", {bus.C_Valid, bus.C_Phase}, 0);
        rchk("abort_stat", 6'h2C, 8'h54, 0);
`ifdef NAND_HOST_IRQ_EN
        check("irq_set", irq, 1);
        wreg(6'h2C, 8'h04);
        check("irq_clr", irq, 0);
`else
        check("irq_tied", irq, 0);
        rchk("irqen_unmapped", 6'h30, 8'h00, 1);
        wreg(6'h2C, 8'h04);
`endif
        rchk("abort_w1c", 6'h2C, 8'h50, 0);

        // reset mid-operation
        wreg(6'h04, 8'h55);
        wreg(6'h00, 8'h21);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_rst_outs", outs(), 0);
        check("mid_rst_pready", bus.PREADY, 1);
        rst_n = 1'b1;
        rchk("mid_rst_stat", 6'h2C, 8'h50, 0);
        rchk("mid_rst_cmd1", 6'h04, 8'h00, 0);
        rchk("mid_rst_ctrl", 6'h00, 8'h00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
